// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event generator and the game FSM that consumes its commands.
// Command codes, key bit positions and the auto-repeat state encoding live here.
package button_event_gen_pkg;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_UP     = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_DOWN   = 3'd3;
    localparam logic [2:0] CMD_LEFT   = 3'd4;
    localparam logic [2:0] CMD_SELECT = 3'd5;

    // Bit positions inside the 5-bit key vector; directions occupy 0..3 so a 2-bit key id maps to code id+1.
    localparam int KEY_UP    = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_LEFT  = 3;
    localparam int KEY_SEL   = 4;
    localparam int NUM_KEYS  = 5;

    typedef enum logic [1:0] {
        RS_IDLE        = 2'd0,
        RS_HOLD_DELAY  = 2'd1,
        RS_HOLD_REPEAT = 2'd2
    } rep_state_t;

    function automatic logic [2:0] dir_to_cmd(input logic [1:0] dir);
        return {1'b0, dir} + 3'd1;
    endfunction

endpackage

// File: rtl/button_event_gen_key_sync_edge.sv
// Two-flop synchronizer per key followed by a previous-level register for rising-edge detection.
// Reset clears every stage, so a key held through reset produces one press after release.
module key_sync_edge
    import button_event_gen_pkg::*;
#(
    parameter int W = NUM_KEYS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_level,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_press
);

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_level;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_sync  = r_sync2;
    assign o_press = r_sync2 & ~r_prev;

endmodule

// File: rtl/button_event_gen.sv
// Turns debounced button levels into one-shot game commands with direction auto-repeat.
// Commands leave through a one-deep slot; anything that cannot be delivered raises sticky ovf.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int TICK_DIV      = 100000,
    parameter int REPEAT_DELAY  = 400,
    parameter int REPEAT_PERIOD = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_in,
    input  logic       right_in,
    input  logic       down_in,
    input  logic       left_in,
    input  logic       s_in,
    // cmd_valid/cmd_code/cmd_repeat are held stable until the cycle where cmd_valid & cmd_ready;
    // that cycle transfers the command and may load the next one back-to-back.
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       cmd_repeat,
    input  logic       cmd_ready,
    output logic       ovf,
    input  logic       ovf_clr,
    output rep_state_t o_dbg_state
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_sync;
    logic [NUM_KEYS-1:0] w_press;
    logic [3:0]          w_dir_sync;
    logic                w_unused_sel_sync;

    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_tick;

    rep_state_t          r_state;
    logic [1:0]          r_rkey;
    logic [RCNT_W-1:0]   r_rcnt;

    logic                w_dir_hit;
    logic [1:0]          w_dir_key;
    logic [2:0]          w_press_code;
    logic                w_any_press;
    logic                w_multi_press;
    logic                w_rkey_held;
    logic                w_cnt_last;
    logic                w_rep_evt;

    logic                w_evt;
    logic                w_load_ok;
    logic                w_xfer;
    logic                w_drop;

    logic                r_valid;
    logic [2:0]          r_code;
    logic                r_repeat;
    logic                r_ovf;

    assign w_level = {s_in, left_in, down_in, right_in, up_in};

    key_sync_edge #(
        .W (NUM_KEYS)
    ) u_key_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (w_level),
        .o_sync  (w_sync),
        .o_press (w_press)
    );

    assign w_dir_sync        = w_sync[3:0];
    assign w_unused_sel_sync = w_sync[KEY_SEL];

    // Free-running repeat time base.
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Press arbitration: select > up > right > down > left.
    always_comb begin
        w_dir_key = 2'd0;
        if (w_press[KEY_UP]) begin
            w_dir_key = 2'd0;
        end else if (w_press[KEY_RIGHT]) begin
            w_dir_key = 2'd1;
        end else if (w_press[KEY_DOWN]) begin
            w_dir_key = 2'd2;
        end else if (w_press[KEY_LEFT]) begin
            w_dir_key = 2'd3;
        end
    end

    assign w_dir_hit     = |w_press[3:0];
    assign w_any_press   = |w_press;
    assign w_multi_press = ((w_press & (w_press - 5'd1)) != 5'd0);

    always_comb begin
        w_press_code = CMD_NONE;
        if (w_press[KEY_SEL]) begin
            w_press_code = CMD_SELECT;
        end else if (w_dir_hit) begin
            w_press_code = dir_to_cmd(w_dir_key);
        end
    end

    assign w_rkey_held = w_dir_sync[r_rkey];
    assign w_cnt_last  = (r_state == RS_HOLD_DELAY) ? (r_rcnt == DELAY_LAST)
                                                    : (r_rcnt == PERIOD_LAST);
    assign w_rep_evt   = (r_state != RS_IDLE) & w_tick & w_rkey_held & w_cnt_last;

    // The repeat FSM follows the highest-priority direction press even when select wins the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RS_IDLE;
            r_rkey  <= 2'd0;
            r_rcnt  <= '0;
        end else if (w_dir_hit) begin
            r_state <= RS_HOLD_DELAY;
            r_rkey  <= w_dir_key;
            r_rcnt  <= '0;
        end else begin
            case (r_state)
                RS_IDLE: begin
                    r_rcnt <= '0;
                end
                RS_HOLD_DELAY, RS_HOLD_REPEAT: begin
                    if (!w_rkey_held) begin
                        r_state <= RS_IDLE;
                        r_rcnt  <= '0;
                    end else if (w_rep_evt) begin
                        r_state <= RS_HOLD_REPEAT;
                        r_rcnt  <= '0;
                    end else if (w_tick) begin
                        r_rcnt  <= r_rcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RS_IDLE;
                    r_rcnt  <= '0;
                end
            endcase
        end
    end

    assign w_xfer    = r_valid & cmd_ready;
    assign w_load_ok = ~r_valid | cmd_ready;
    assign w_evt     = w_any_press | w_rep_evt;
    assign w_drop    = w_multi_press | (w_any_press & w_rep_evt) | (w_evt & ~w_load_ok);

    // A press always outranks a repeat arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_code   <= CMD_NONE;
            r_repeat <= 1'b0;
        end else if (w_evt && w_load_ok) begin
            r_valid  <= 1'b1;
            r_code   <= w_any_press ? w_press_code : dir_to_cmd(r_rkey);
            r_repeat <= ~w_any_press;
        end else if (w_xfer) begin
            r_valid  <= 1'b0;
            r_code   <= CMD_NONE;
            r_repeat <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign cmd_valid   = r_valid;
    assign cmd_code    = r_code;
    assign cmd_repeat  = r_repeat;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: directed scenarios plus random key activity, all checked
// cycle by cycle against a behavioural model and a transfer scoreboard.
module tb_button_event_gen;
    import button_event_gen_pkg::*;

    localparam int TICK_DIV      = 4;
    localparam int REPEAT_DELAY  = 3;
    localparam int REPEAT_PERIOD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] keys;
    logic       cmd_ready;
    logic       ovf_clr;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_repeat;
    logic       ovf;
    rep_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    // Model: input delay line, tick phase, armed key and ticks since arming, slot and ovf.
    logic [4:0] lvl_q[$];
    int         m_phase;
    int         m_key;
    int         m_ticks;
    logic       m_valid;
    logic [2:0] m_code;
    logic       m_rpt;
    logic       m_ovf;

    logic [3:0] exp_q[$];
    int         log_cyc[$];
    logic [2:0] log_code[$];
    logic       log_rpt[$];

    button_event_gen #(
        .TICK_DIV      (TICK_DIV),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .up_in       (keys[0]),
        .right_in    (keys[1]),
        .down_in     (keys[2]),
        .left_in     (keys[3]),
        .s_in        (keys[4]),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_repeat  (cmd_repeat),
        .cmd_ready   (cmd_ready),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc_no, obs, exp);
        end
    endtask

    function automatic bit fires(input int n);
        return (n >= REPEAT_DELAY) && (((n - REPEAT_DELAY) % REPEAT_PERIOD) == 0);
    endfunction

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        logic [4:0] s2;
        logic [4:0] pr;
        logic       tick;
        logic       rep;
        logic       drop;
        logic [2:0] rep_code;
        logic [2:0] win_code;
        int         dir;
        int         npress;
        if (rst) begin
            lvl_q   = '{5'd0, 5'd0, 5'd0};
            m_phase = 0;
            m_key   = -1;
            m_ticks = 0;
            m_valid = 1'b0;
            m_code  = 3'd0;
            m_rpt   = 1'b0;
            m_ovf   = 1'b0;
            return;
        end
        s2   = lvl_q[1];
        pr   = s2 & ~lvl_q[2];
        tick = (m_phase == TICK_DIV - 1);
        rep  = 1'b0;
        rep_code = 3'd0;
        if (m_key >= 0) begin
            rep_code = 3'(m_key + 1);
            if (tick && s2[m_key]) rep = fires(m_ticks + 1);
        end
        dir = -1;
        for (int i = 3; i >= 0; i--) if (pr[i]) dir = i;
        if (dir >= 0) begin
            m_key   = dir;
            m_ticks = 0;
        end else if (m_key >= 0 && !s2[m_key]) begin
            m_key = -1;
        end else if (m_key >= 0 && tick) begin
            m_ticks++;
        end
        npress   = $countones(pr);
        win_code = pr[4] ? 3'd5 : ((dir >= 0) ? 3'(dir + 1) : 3'd0);
        drop     = (npress > 1) || (rep && npress > 0);
        if (m_valid && cmd_ready) exp_q.push_back({m_code, m_rpt});
        if (npress > 0 || rep) begin
            if (!m_valid || cmd_ready) begin
                m_valid = 1'b1;
                m_code  = (npress > 0) ? win_code : rep_code;
                m_rpt   = (npress == 0);
            end else begin
                drop = 1'b1;
            end
        end else if (m_valid && cmd_ready) begin
            m_valid = 1'b0;
            m_code  = 3'd0;
            m_rpt   = 1'b0;
        end
        m_ovf   = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        m_phase = (m_phase + 1) % TICK_DIV;
        lvl_q.push_front(keys);
        void'(lvl_q.pop_back());
    endtask

    task automatic step_cycle();
        model_step();
        if (!rst && cmd_valid === 1'b1 && cmd_ready) begin
            log_cyc.push_back(cyc_no);
            log_code.push_back(cmd_code);
            log_rpt.push_back(cmd_repeat);
            if (exp_q.size() == 0) check("sb_extra", 32'(1), 32'(0));
            else check("sb_xfer", 32'({cmd_code, cmd_repeat}), 32'(exp_q.pop_front()));
        end
        @(negedge clk);
        cyc_no++;
        check("out", 32'({cmd_valid, cmd_code, cmd_repeat, ovf}), 32'({m_valid, m_code, m_rpt, m_ovf}));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_code.delete();
        log_rpt.delete();
    endtask

    // rpt < 0 matches either flag.
    function automatic int count_log(input logic [2:0] code, input int rpt);
        int c = 0;
        for (int i = 0; i < log_code.size(); i++)
            if (log_code[i] == code && (rpt < 0 || int'(log_rpt[i]) == rpt)) c++;
        return c;
    endfunction

    function automatic int log_gap(input int i);
        return (log_cyc.size() > i) ? (log_cyc[i] - log_cyc[i-1]) : -1;
    endfunction

    initial begin
        keys      = 5'd0;
        rst       = 1'b1;
        cmd_ready = 1'b1;
        ovf_clr   = 1'b0;
        lvl_q     = '{5'd0, 5'd0, 5'd0};
        m_phase   = 0;
        m_key     = -1;
        m_ticks   = 0;
        m_valid   = 1'b0;
        m_code    = 3'd0;
        m_rpt     = 1'b0;
        m_ovf     = 1'b0;

        run(3);
        check("reset_out", 32'({cmd_valid, cmd_code, cmd_repeat, ovf}), 32'(0));
        check("reset_state", 32'(dbg_state), 32'(RS_IDLE));
        rst = 1'b0;
        run(4);

        // Single tap of up.
        clear_log();
        keys[0] = 1'b1;
        run(2);
        check("tap_early", 32'(cmd_valid), 32'(0));
        run(1);
        check("tap_lat", 32'({cmd_valid, cmd_code, cmd_repeat}), 32'({1'b1, CMD_UP, 1'b0}));
        run(2);
        keys[0] = 1'b0;
        run(20);
        check("tap_count", 32'(log_code.size()), 32'(1));
        check("tap_ovf", 32'(ovf), 32'(0));

        // Long hold of left: one press then evenly spaced repeats.
        clear_log();
        keys[3] = 1'b1;
        run(60);
        keys[3] = 1'b0;
        run(20);
        check("left_init", 32'(count_log(CMD_LEFT, 0)), 32'(1));
        check("left_other", 32'(log_code.size() - count_log(CMD_LEFT, -1)), 32'(0));
        check("left_rep_min", 32'(count_log(CMD_LEFT, 1) >= 5), 32'(1));
        check("left_first_gap", 32'(log_gap(1) >= 9 && log_gap(1) <= 12), 32'(1));
        for (int i = 2; i < log_cyc.size(); i++) check("left_gap", 32'(log_gap(i)), 32'(8));

        // Select and up together.
        clear_log();
        keys = 5'b10001;
        run(3);
        check("sel_code", 32'({cmd_valid, cmd_code, cmd_repeat}), 32'({1'b1, CMD_SELECT, 1'b0}));
        check("sel_ovf", 32'(ovf), 32'(1));
        keys = 5'd0;
        run(6);
        check("sel_count", 32'(log_code.size()), 32'(1));
        ovf_clr = 1'b1;
        run(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'(0));

        // Backpressure: right held in the slot, down dropped.
        clear_log();
        cmd_ready = 1'b0;
        keys[1] = 1'b1;
        run(10);
        keys[2] = 1'b1;
        run(4);
        check("bp_code", 32'({cmd_valid, cmd_code}), 32'({1'b1, CMD_RIGHT}));
        check("bp_ovf", 32'(ovf), 32'(1));
        keys = 5'd0;
        run(5);
        check("bp_hold", 32'({cmd_valid, cmd_code, cmd_repeat}), 32'({1'b1, CMD_RIGHT, 1'b0}));
        cmd_ready = 1'b1;
        run(1);
        check("bp_xfer_cnt", 32'(log_code.size()), 32'(1));
        check("bp_xfer_code", 32'((log_code.size() > 0) ? log_code[0] : 3'd7), 32'(CMD_RIGHT));
        check("bp_empty", 32'(cmd_valid), 32'(0));
        ovf_clr = 1'b1;
        run(1);
        ovf_clr = 1'b0;

        // Direction change while repeating.
        keys[1] = 1'b1;
        run(30);
        keys[2] = 1'b1;
        run(3);
        check("chg_press", 32'({cmd_valid, cmd_code, cmd_repeat}), 32'({1'b1, CMD_DOWN, 1'b0}));
        clear_log();
        run(40);
        check("chg_code", 32'(log_code.size() - count_log(CMD_DOWN, -1)), 32'(0));
        check("chg_first_gap", 32'(log_gap(1) >= 9 && log_gap(1) <= 12), 32'(1));
        keys[1] = 1'b0;
        clear_log();
        run(30);
        check("rel_right_rep", 32'(count_log(CMD_DOWN, 1) >= 3), 32'(1));
        check("rel_right_other", 32'(log_code.size() - count_log(CMD_DOWN, 1)), 32'(0));
        keys[2] = 1'b0;
        run(4);
        clear_log();
        run(20);
        check("rel_down_idle", 32'(log_code.size()), 32'(0));
        check("rel_down_state", 32'(dbg_state), 32'(RS_IDLE));

        // Reset in the middle of a down repeat.
        keys[2] = 1'b1;
        run(30);
        rst = 1'b1;
        run(1);
        check("rst_mid1", 32'({cmd_valid, cmd_code, cmd_repeat, ovf}), 32'(0));
        run(1);
        check("rst_mid2", 32'({cmd_valid, cmd_code, cmd_repeat, ovf}), 32'(0));
        rst = 1'b0;
        clear_log();
        run(2);
        check("rst_early", 32'(cmd_valid), 32'(0));
        run(1);
        check("rst_press", 32'({cmd_valid, cmd_code, cmd_repeat}), 32'({1'b1, CMD_DOWN, 1'b0}));
        run(30);
        keys = 5'd0;
        run(10);
        check("rst_init_count", 32'(count_log(CMD_DOWN, 0)), 32'(1));
        check("rst_first_gap", 32'(log_gap(1) >= 9 && log_gap(1) <= 12), 32'(1));

        // Random key activity, backpressure, clears and occasional reset.
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 39) == 0) keys[k] = ~keys[k];
            cmd_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            step_cycle();
        end
        rst       = 1'b0;
        ovf_clr   = 1'b0;
        keys      = 5'd0;
        cmd_ready = 1'b1;
        run(10);
        check("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
